ap_sel_stack: RTL and testbench
===============================

AP_SEL_STACK -- requirements
Module: ap_sel_stack

Interface
REQ-001 SHALL have parameter SEL_W, default 3, meaning the width of the address-pointer select output.
REQ-002 SHALL have parameter DEPTH, default 4, meaning the number of save/restore stack entries (legal range 1..16).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port ap_set, input, SEL_W+1 bits: the set code; 0 = no action, k = select k-1.
REQ-006 SHALL have port push, input, 1 bit: save the current ap_sel onto the stack.
REQ-007 SHALL have port pop, input, 1 bit: restore ap_sel from the top of the stack.
REQ-008 SHALL have port err_clr, input, 1 bit: clear all sticky error flags.
REQ-009 SHALL have port ap_sel, output, SEL_W bits: the registered current pointer select.
REQ-010 SHALL have port level, output, clog2(DEPTH+1) bits: the registered count of stack entries in use.
REQ-011 SHALL have port full, output, 1 bit: asserted when level == DEPTH (combinational from level).
REQ-012 SHALL have port empty, output, 1 bit: asserted when level == 0 (combinational from level).
REQ-013 SHALL have port err, output, 3 bits: registered sticky flags {range, underflow, overflow}.

Function
REQ-014 A legal ap_set is 1..2^SEL_W; on the next edge ap_sel SHALL become ap_set-1, giving 1-cycle latency.
REQ-015 When ap_set == 0, ap_sel SHALL hold its value.
REQ-016 When ap_set > 2^SEL_W, the code is out of range; ap_sel SHALL hold and err[2] SHALL be set.
REQ-017 On push with !full and !pop, the stack SHALL store the pre-edge ap_sel at index level and increment level.
REQ-018 On pop with !empty and !push, ap_sel SHALL take the top entry and level SHALL decrement.
REQ-019 A push and a pop in the same cycle SHALL be a stack no-op: level is unchanged and no error is raised; ap_set still applies.
REQ-020 A push together with a legal ap_set SHALL save the old ap_sel and load ap_set-1, so a call-style switch completes in one cycle.
REQ-021 A pop together with a legal ap_set SHALL still decrement level, and ap_sel SHALL take ap_set-1, discarding the popped entry.
REQ-022 A push while full SHALL be ignored and SHALL set err[0]; a pop while empty SHALL be ignored and SHALL set err[1].
REQ-023 Error flags SHALL stay set until err_clr; if err_clr and a new error occur in the same cycle, the flag SHALL end up set.
REQ-024 Stack entries not in use SHALL NOT be observable at any output.

Reset
REQ-025 While rst is high, ap_sel, level and err SHALL be 0 immediately, independent of clk; empty=1 and full=0.
REQ-026 Stack contents SHALL need no reset; after reset, level=0 makes them unreachable.
REQ-027 If reset is asserted mid-sequence, any pending push or pop SHALL be discarded; the first edge after deassertion SHALL behave as a normal cycle.

Configuration
REQ-028 Macro AP_SEL_STACK_ERR_EN, when defined, SHALL compile in the err register, err_clr handling and the error-setting conditions of REQ-016, REQ-022 and REQ-023.
REQ-029 Without AP_SEL_STACK_ERR_EN, err SHALL be constant 0 and err_clr SHALL be ignored; ignore/hold behaviour SHALL be unchanged.

Verification
REQ-030 Defaults, reset released, ap_set=5 for one cycle -> ap_sel=4 on the next edge; then ap_set=0 for 3 cycles -> ap_sel stays 4.
REQ-031 ap_sel=4, push with ap_set=2 -> ap_sel=1, level=1; then pop -> ap_sel=4, level=0, empty=1.
REQ-032 Four pushes -> full=1, level=4; a fifth push -> level stays 4 and err=3'b001 (macro on); err_clr -> err=0.
REQ-033 empty, pop -> ap_sel unchanged and err=3'b010; with push=pop=1 at level 2 -> level stays 2 and err unchanged.
REQ-034 ap_set=12 with SEL_W=3 -> ap_sel holds and err[2]=1; rst pulsed between edges at level 3 -> ap_sel=0, level=0 asynchronously.
REQ-035 Repeat REQ-032 and REQ-034 without the macro -> err constantly 0, and all other responses are identical.

Source files
------------

// File: rtl/ap_sel_stack.sv
// Address-pointer select register with a small save/restore stack for call-style switching.
// Optional sticky error flags are compiled in with `define AP_SEL_STACK_ERR_EN.
module ap_sel_stack #(
  parameter  int SEL_W = 3,
  parameter  int DEPTH = 4,
  localparam int LW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SEL_W:0]   ap_set,
  input  logic             push,
  input  logic             pop,
  input  logic             err_clr,
  output logic [SEL_W-1:0] ap_sel,
  output logic [LW-1:0]    level,
  output logic             full,
  output logic             empty,
  output logic [2:0]       err
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [SEL_W:0] SET_MAX = {1'b1, {SEL_W{1'b0}}};
  localparam logic [SEL_W:0] SET_ONE = {{SEL_W{1'b0}}, 1'b1};

  logic [SEL_W-1:0] ap_sel_q, ap_sel_d;
  logic [LW-1:0]    level_q, level_d;
  logic [SEL_W-1:0] stk_q [0:(1<<IW)-1];
  logic [SEL_W:0]   set_m1;
  logic             set_legal, do_push, do_pop;

  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);

  assign set_legal = (ap_set != '0) && (ap_set <= SET_MAX);
  assign set_m1    = ap_set - SET_ONE;
  // Simultaneous push and pop cancel out at the stack.
  assign do_push   = push && !pop && !full;
  assign do_pop    = pop && !push && !empty;

  always_comb begin
    ap_sel_d = ap_sel_q;
    level_d  = level_q;
    if (do_push) level_d = level_q + LW'(1);
    if (do_pop) begin
      level_d  = level_q - LW'(1);
      ap_sel_d = stk_q[IW'(level_q - LW'(1))];
    end
    // A legal set code wins over the popped value.
    if (set_legal) ap_sel_d = set_m1[SEL_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ap_sel_q <= '0;
      level_q  <= '0;
    end else begin
      ap_sel_q <= ap_sel_d;
      level_q  <= level_d;
    end
  end

  // Entries are unreachable past level, so the storage needs no reset.
  always_ff @(posedge clk) begin
    if (do_push && !rst) stk_q[IW'(level_q)] <= ap_sel_q;
  end

  assign ap_sel = ap_sel_q;
  assign level  = level_q;

`ifdef AP_SEL_STACK_ERR_EN
  logic [2:0] err_q, err_d, err_new;

  always_comb begin
    err_new    = '0;
    err_new[0] = push && !pop && full;
    err_new[1] = pop && !push && empty;
    err_new[2] = (ap_set > SET_MAX);
    err_d      = (err_clr ? 3'b000 : err_q) | err_new;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= '0;
    else     err_q <= err_d;
  end

  assign err = err_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign err = 3'b000;
`endif

endmodule

// File: tb/tb_ap_sel_stack.sv
// Randomized bench for ap_sel_stack against a queue-based reference model,
// with directed scenarios for the call/return, full/empty, range and async reset cases.
module tb_ap_sel_stack;
  localparam int SEL_W = 3;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH + 1);
`ifdef AP_SEL_STACK_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [SEL_W:0]   ap_set;
  logic             push, pop, err_clr;
  logic [SEL_W-1:0] ap_sel;
  logic [LW-1:0]    level;
  logic             full, empty;
  logic [2:0]       err;

  ap_sel_stack #(.SEL_W(SEL_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .ap_set(ap_set), .push(push), .pop(pop),
    .err_clr(err_clr), .ap_sel(ap_sel), .level(level), .full(full),
    .empty(empty), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // reference model
  int m_sel;
  int m_stk[$];
  int m_err;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".ap_sel"}, int'(ap_sel), m_sel);
    chk({tag, ".level"}, int'(level), m_stk.size());
    chk({tag, ".full"}, int'(full), int'(m_stk.size() == DEPTH));
    chk({tag, ".empty"}, int'(empty), int'(m_stk.size() == 0));
    chk({tag, ".err"}, int'(err), m_err);
  endtask

  function automatic void model_reset();
    m_sel = 0;
    m_stk.delete();
    m_err = 0;
  endfunction

  function automatic void model_step(input int s, input bit pu, input bit po, input bit ec);
    int nsel = m_sel;
    int nerr = 0;
    if (pu && !po) begin
      if (m_stk.size() == DEPTH) nerr |= 1;
      else m_stk.push_back(m_sel);
    end
    if (po && !pu) begin
      if (m_stk.size() == 0) nerr |= 2;
      else nsel = m_stk.pop_back();
    end
    if (s >= 1 && s <= (1 << SEL_W)) nsel = s - 1;
    if (s > (1 << SEL_W)) nerr |= 4;
    m_sel = nsel;
    if (ERR_EN) m_err = (ec ? 0 : m_err) | nerr;
  endfunction

  task automatic cyc(input string tag, input int s, input bit pu, input bit po, input bit ec);
    ap_set = s[SEL_W:0]; push = pu; pop = po; err_clr = ec;
    @(posedge clk);
    model_step(s, pu, po, ec);
    #1;
    chk_all(tag);
  endtask

  // Pulse reset between edges and check the outputs clear without a clock.
  task automatic rst_pulse(input string tag);
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk_all(tag);
    #1 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ap_set = '0; push = 1'b0; pop = 1'b0; err_clr = 1'b0;
    model_reset();
    #3;
    chk_all("reset");
    @(negedge clk) rst = 1'b0;

    // select with one-cycle latency, then hold
    cyc("set5", 5, 0, 0, 0);
    chk("set5.const", int'(ap_sel), 4);
    for (int i = 0; i < 3; i++) cyc("hold", 0, 0, 0, 0);
    chk("hold.const", int'(ap_sel), 4);

    // call-style switch and return
    cyc("call", 2, 1, 0, 0);
    chk("call.const", int'(ap_sel), 1);
    cyc("ret", 0, 0, 1, 0);
    chk("ret.const", int'(ap_sel), 4);
    chk("ret.empty", int'(empty), 1);

    // fill, overflow, clear
    for (int i = 0; i < DEPTH; i++) cyc("fill", i + 1, 1, 0, 0);
    chk("fill.full", int'(full), 1);
    cyc("ovf", 0, 1, 0, 0);
    chk("ovf.level", int'(level), DEPTH);
    chk("ovf.err", int'(err), ERR_EN ? 1 : 0);
    cyc("clr", 0, 0, 0, 1);
    chk("clr.err", int'(err), 0);

    // pop with an overriding set discards the popped entry
    cyc("popset", 7, 0, 1, 0);
    chk("popset.sel", int'(ap_sel), 6);
    for (int i = 0; i < DEPTH - 1; i++) cyc("drain", 0, 0, 1, 0);
    cyc("unf", 0, 0, 1, 0);
    chk("unf.err", int'(err), ERR_EN ? 2 : 0);

    // push+pop at level 2 is a stack no-op; clear and set error in one cycle
    cyc("p1", 0, 1, 0, 0);
    cyc("p2", 3, 1, 0, 0);
    cyc("pp", 6, 1, 1, 0);
    chk("pp.level", int'(level), 2);
    chk("pp.err", int'(err), ERR_EN ? 2 : 0);
    cyc("clrset", 12, 0, 0, 1);
    chk("range.sel", int'(ap_sel), 5);
    chk("range.err", int'(err), ERR_EN ? 4 : 0);

    // async reset at level 3
    cyc("p3", 0, 1, 0, 0);
    chk("p3.level", int'(level), 3);
    rst_pulse("arst");
    chk("arst.level", int'(level), 0);
    cyc("post_rst", 0, 1, 0, 0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      int s;
      int r = $urandom_range(0, 99);
      s = (r < 55) ? 0 : int'($urandom_range(0, 15));
      cyc("rnd", s, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
          $urandom_range(0, 15) == 0);
      if ($urandom_range(0, 199) == 0) rst_pulse("rnd_rst");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
